// File: rtl/underflow_arbiter_pkg.sv
// underflow_arbiter_pkg: shared types and modular subtract helper for the arbitrated down-counter.
package underflow_arbiter_pkg;

  typedef enum logic {IDLE, APPLY} state_t;

  // Works on any width up to 32; returns {borrow, diff} with diff masked to w bits.
  function automatic logic [32:0] sub_borrow(input logic [31:0] a, input logic [31:0] b, input int unsigned w);
    logic [31:0] m;
    m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return {b > a, (a - b) & m};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping upward.
module rr_arbiter
  import underflow_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);
  logic [IW-1:0] j;
  // Scan from the farthest offset down so the nearest set request is written last.
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N_REQ);
      if (req[j]) idx = j;
    end
  end
  assign any = |req;
  assign gnt = any ? (N_REQ'(1) << idx) : '0;
endmodule

// File: rtl/underflow_arbiter.sv
// underflow_arbiter: round-robin shared modular down-counter with load priority and borrow reporting.
module underflow_arbiter
  import underflow_arbiter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int N_REQ = 4,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] step,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_val,
  output logic [N_REQ-1:0]       gnt,
  output logic                   load_ack,
  output logic [WIDTH-1:0]       count,
  output logic                   borrow,
  output logic                   busy
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d, step_q, step_d;
  logic [IW-1:0]     ptr_q, ptr_d, win_q, win_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d, arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic [32:0]       sub_r;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(req),
    .ptr(ptr_q),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );

  assign sub_r = sub_borrow(32'(count_q), 32'(step_q), WIDTH);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d = ptr_q;
    win_d = win_q;
    gnt_d = gnt_q;
    step_d = step_q;
    if (state_q == APPLY) begin
      count_d = WIDTH'(sub_r[31:0]);
      ptr_d = (int'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;
      state_d = IDLE;
    end else if (load) begin
      count_d = load_val;
    end else if (arb_any) begin
      win_d = arb_idx;
      gnt_d = arb_gnt;
      step_d = step[arb_idx*WIDTH +: WIDTH];
      state_d = APPLY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= INIT;
      ptr_q <= '0;
      win_q <= '0;
      gnt_q <= '0;
      step_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      gnt_q <= gnt_d;
      step_q <= step_d;
    end
  end

  // Pulses come straight from the state so they line up with the count update edge.
  assign busy = state_q == APPLY;
  assign gnt = busy ? gnt_q : '0;
  assign borrow = busy & sub_r[32];
  assign load_ack = !busy & load;
  assign count = count_q;
endmodule

// File: tb/tb_underflow_arbiter.sv
// tb_underflow_arbiter: table-driven directed checks plus an async-reset-mid-APPLY sequence.
module tb_underflow_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [11:0] step = '0;
  logic        load = 1'b0;
  logic [2:0]  load_val = '0;
  logic [3:0]  gnt;
  logic        load_ack, borrow, busy;
  logic [2:0]  count;
  int          total = 0;
  int          passed = 0;

  typedef struct {
    logic rst; logic [3:0] req; logic [11:0] step; logic load; logic [2:0] lval;
    logic [3:0] gnt; logic brw; logic ack; logic busy; logic [2:0] cnt;
  } vec_t;
  vec_t tv[$];

  underflow_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .step(step), .load(load), .load_val(load_val),
    .gnt(gnt), .load_ack(load_ack), .count(count), .borrow(borrow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic v(input logic r, input logic [3:0] rq, input logic [11:0] st, input logic ld,
                   input logic [2:0] lv, input logic [3:0] g, input logic b, input logic a,
                   input logic bz, input logic [2:0] c);
    vec_t e;
    e.rst = r; e.req = rq; e.step = st; e.load = ld; e.lval = lv;
    e.gnt = g; e.brw = b; e.ack = a; e.busy = bz; e.cnt = c;
    tv.push_back(e);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] a_cnt [8];
    logic       a_brw [8];
    a_cnt = '{3'd7, 3'd4, 3'd1, 3'd6, 3'd3, 3'd0, 3'd5, 3'd2};
    a_brw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    v(1, 4'h0, 12'h000, 0, 0, 4'h0, 0, 0, 0, 7);
    for (int k = 0; k < 8; k++) begin
      v(0, 4'h1, 12'h003, 0, 0, 4'h0, 0, 0, 0, a_cnt[k]);
      v(0, 4'h1, 12'h003, 0, 0, 4'h1, a_brw[k], 0, 1, a_cnt[k]);
    end
    v(0, 4'h0, 12'h000, 0, 0, 4'h0, 0, 0, 0, 7);
    v(1, 4'h0, 12'h000, 0, 0, 4'h0, 0, 0, 0, 7);
    v(0, 4'h5, 12'h081, 0, 0, 4'h0, 0, 0, 0, 7);
    v(0, 4'h5, 12'h081, 0, 0, 4'h1, 0, 0, 1, 7);
    v(0, 4'h5, 12'h081, 0, 0, 4'h0, 0, 0, 0, 6);
    v(0, 4'h5, 12'h081, 0, 0, 4'h4, 0, 0, 1, 6);
    v(0, 4'h5, 12'h081, 0, 0, 4'h0, 0, 0, 0, 4);
    v(0, 4'h5, 12'h081, 0, 0, 4'h1, 0, 0, 1, 4);
    v(0, 4'h5, 12'h081, 0, 0, 4'h0, 0, 0, 0, 3);
    v(0, 4'h5, 12'h081, 0, 0, 4'h4, 0, 0, 1, 3);
    v(0, 4'h0, 12'h000, 0, 0, 4'h0, 0, 0, 0, 1);
    v(0, 4'h2, 12'h010, 1, 5, 4'h0, 0, 1, 0, 1);
    v(0, 4'h2, 12'h010, 0, 0, 4'h0, 0, 0, 0, 5);
    v(0, 4'h2, 12'h010, 0, 0, 4'h2, 0, 0, 1, 5);
    v(0, 4'h0, 12'h000, 0, 0, 4'h0, 0, 0, 0, 3);
    v(0, 4'h2, 12'h010, 0, 0, 4'h0, 0, 0, 0, 3);
    v(0, 4'h2, 12'h010, 1, 6, 4'h2, 0, 0, 1, 3);
    v(0, 4'h0, 12'h000, 1, 6, 4'h0, 0, 1, 0, 1);
    v(0, 4'h0, 12'h000, 0, 0, 4'h0, 0, 0, 0, 6);
    v(0, 4'h0, 12'h000, 1, 3, 4'h0, 0, 1, 0, 6);
    v(0, 4'h1, 12'h000, 0, 0, 4'h0, 0, 0, 0, 3);
    v(0, 4'h1, 12'h000, 0, 0, 4'h1, 0, 0, 1, 3);
    v(0, 4'h0, 12'h000, 1, 0, 4'h0, 0, 1, 0, 3);
    v(0, 4'h1, 12'h007, 0, 0, 4'h0, 0, 0, 0, 0);
    v(0, 4'h1, 12'h007, 0, 0, 4'h1, 1, 0, 1, 0);
    v(0, 4'h0, 12'h000, 1, 4, 4'h0, 0, 1, 0, 1);
    v(0, 4'h1, 12'h004, 0, 0, 4'h0, 0, 0, 0, 4);
    v(0, 4'h1, 12'h004, 0, 0, 4'h1, 0, 0, 1, 4);
    v(0, 4'h0, 12'h000, 0, 0, 4'h0, 0, 0, 0, 0);

    tick();
    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst; req = tv[i].req; step = tv[i].step;
      load = tv[i].load; load_val = tv[i].lval;
      #3;
      chk("gnt", i, 32'(gnt), 32'(tv[i].gnt));
      chk("borrow", i, 32'(borrow), 32'(tv[i].brw));
      chk("load_ack", i, 32'(load_ack), 32'(tv[i].ack));
      chk("busy", i, 32'(busy), 32'(tv[i].busy));
      chk("count", i, 32'(count), 32'(tv[i].cnt));
      tick();
    end

    // Pointer is 1 here; reset mid-APPLY must abort and return the pointer to 0.
    req = 4'h3; step = 12'h00B; load = 1'b0;
    tick();
    chk("pre_rst_busy", 0, 32'(busy), 32'd1);
    chk("pre_rst_gnt", 0, 32'(gnt), 32'h2);
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt", 0, 32'(gnt), 32'h0);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_count", 0, 32'(count), 32'd7);
    chk("rst_borrow", 0, 32'(borrow), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_gnt", 0, 32'(gnt), 32'h1);
    chk("post_rst_count", 0, 32'(count), 32'd7);
    chk("post_rst_borrow", 0, 32'(borrow), 32'd0);
    req = 4'h0;
    tick();
    chk("post_rst_result", 0, 32'(count), 32'd4);
    chk("post_rst_idle", 0, 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/underflow_arbiter.md
Name: underflow_arbiter

Overview:
- Shares one modular down-counter (WIDTH bits, wraps on underflow) between N_REQ requesters.
- Each requester asks to subtract its own step value. A round-robin arbiter picks one request per operation.
- The controller applies the subtraction, reports a borrow (underflow) pulse, and supports a synchronous load of the counter.
- Sits between the requester logic and the shared counter datapath, replacing free-running decrement with arbitrated, sequenced updates.

Parameters:
- WIDTH, 3, counter width in bits.
- N_REQ, 4, number of requesters (≥2).
- INIT, {WIDTH{1'b1}} (7 at default), counter value after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request level; held high until matching gnt.
- step  input  N_REQ*WIDTH  packed step values; requester i uses bits [i*WIDTH +: WIDTH]; must be stable while req[i] is high.
- load  input  1  request to overwrite counter; held high until load_ack.
- load_val  input  WIDTH  value written on load.
- gnt  output  N_REQ  one-hot, one-cycle pulse; marks the cycle the requester's subtraction is committed.
- load_ack  output  1  one-cycle pulse; marks the cycle load_val is committed.
- count  output  WIDTH  current counter value (registered).
- borrow  output  1  one-cycle pulse, coincident with gnt, when the subtraction wrapped.
- busy  output  1  high while state is APPLY.

Behaviour:
- Reset (async, rst=1): count=INIT, gnt=0, load_ack=0, borrow=0, busy=0, rr pointer=0, state=IDLE. Reset mid-APPLY aborts the operation: no gnt, count returns to INIT.
- FSM states: IDLE, APPLY.
- IDLE, load=1:
  - count<=load_val; load_ack=1 that cycle.
  - No arbitration that cycle; stay IDLE.
  - Load has priority over req.
- IDLE, load=0 and |req:
  - Winner = first set req at or after the pointer, scanning upward with wrap.
  - Latch the winner index and its step; go to APPLY.
- IDLE, no load and no req: hold.
- APPLY (exactly 1 cycle):
  - count<=(count-step_latched) mod 2^WIDTH.
  - borrow=1 iff step_latched > count (unsigned compare, old count).
  - gnt[winner]=1; pointer<=(winner+1) mod N_REQ; next state IDLE.
- Outputs gnt, borrow and load_ack are driven combinationally from the state and latched registers in their commit cycle, so each is a one-cycle pulse aligned with the count update edge.
- A load arriving during APPLY is not lost: it stays pending (held by the requester) and is served in the following IDLE cycle, ahead of any req.
- Latency: req seen in IDLE at cycle t → gnt and count update at the end of cycle t+1. Peak throughput is one subtraction per 2 cycles.
- Boundary cases:
  - step=0: gnt issued, count unchanged, borrow=0.
  - step==count: count=0, borrow=0.
  - step=2^WIDTH-1 with count=0: count=1, borrow=1.
  - A req dropped before gnt is a protocol violation; the latched operation still commits.
  - Pointer update only in APPLY; loads do not move the pointer.

Decomposition:
- Package underflow_arbiter_pkg:
  - state enum (IDLE, APPLY);
  - helper function for modular subtract-with-borrow, returning {borrow, diff}.
- One sub-module: rr_arbiter, with parameter N_REQ.
  - Inputs: req, ptr. Outputs: onehot grant, index, any.
  - Combinational, reusable by other shared-resource controllers.

Test Plan:
- Reset, then hold req[0]=1 with step0=3 for 8 operations → count sequence 4,1,6,3,0,5,2,7. borrow pulses on the 1→6, 0→5 and 2→7 steps. gnt[0] pulses every 2nd cycle.
- req[0] and req[2] held, steps 1 and 2, start 7 → grants alternate 0,2,0,2; count goes 6,4,3,1. The pointer never skips a requester.
- load=1 with load_val=5 asserted in the same cycle as req[1] in IDLE → load_ack first, count=5. gnt[1] follows 2 cycles later, with count=5-step1.
- load asserted during APPLY → the subtraction commits first, then load_ack in the next cycle; the final count equals load_val.
- Edge steps → step0=0 on count 3 gives count 3, borrow 0. step=7 on count 0 gives count 1, borrow 1. step=count=4 gives count 0, borrow 0.
- rst pulsed asynchronously mid-APPLY → no gnt that cycle. count=7, busy=0 and pointer=0 immediately; normal operation resumes after rst deasserts.
